// File: rtl/fetch_module_pkg.sv
// Shared types and constants for the fetch front end.
// Build option: FETCH_STATIC_BRANCH_EN lets fetch follow unconditional B
// instructions itself instead of waiting for a ROB redirect.
package fetch_module_pkg;

    localparam int GPR_SIZE = 64;

    localparam logic [31:0] HLT_INSNBITS = 32'hD440_0000;
    localparam logic [5:0]  OP_B         = 6'b000101;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]         insnbits;
        logic [GPR_SIZE-1:0] pc;
    } fetch_entry_t;

    // Target of an unconditional B: pc + sign-extended (imm26 << 2), wrapping modulo 2^64.
    function automatic logic [GPR_SIZE-1:0] branchTarget(input logic [GPR_SIZE-1:0] pc,
                                                         input logic [31:0] insn);
        return pc + {{(GPR_SIZE-28){insn[25]}}, insn[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small instruction FIFO between the memory response and dispatch.
// Flush wins over push and pop. The head reads as all zeros when the FIFO is empty.
module fetch_queue
    import fetch_module_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   i_clk,
    input  logic                   i_rstN,
    input  logic                   i_push,
    input  fetch_entry_t           i_pushEntry,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_count  = r_count;
    assign w_doPop  = i_pop && !i_flush && !o_empty;
    assign w_doPush = i_push && !i_flush && (!o_full || w_doPop);
    assign o_head   = o_empty ? '0 : r_mem[r_rdPtr];

    // Pointers wrap naturally; the count sits beside them to tell full from empty.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count decides which entries are visible.
    always_ff @(posedge i_clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_pushEntry;
    end

endmodule

// File: rtl/fetch_module.sv
// Fetch stage: owns the PC, issues one-word requests to a synchronous
// instruction memory, buffers responses in fetch_queue and hands one
// instruction per cycle to dispatch. ROB redirects squash everything younger,
// and fetch stops once HLT has been enqueued.
// Build option: FETCH_STATIC_BRANCH_EN follows unconditional B at enqueue time.
module fetch_module
    import fetch_module_pkg::*;
#(
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [GPR_SIZE-1:0] RESET_PC    = '0
)(
    input  logic                in_clk,
    input  logic                in_rst,
    output logic                out_imem_req,
    output logic [GPR_SIZE-1:0] out_imem_addr,
    input  logic                in_imem_valid,
    input  logic [31:0]         in_imem_insnbits,
    output logic                out_d_done,
    output logic [31:0]         out_d_insnbits,
    output logic [GPR_SIZE-1:0] out_d_pc,
    input  logic                in_d_stall,
    input  logic                in_rob_is_mispred,
    input  logic [GPR_SIZE-1:0] in_rob_redirect_pc,
    output logic                out_halted
);

    localparam int              CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W+1)'(QUEUE_DEPTH);

    fetch_state_t        r_state;
    fetch_state_t        w_nextState;
    logic [GPR_SIZE-1:0] r_pc;
    logic [GPR_SIZE-1:0] r_inflightPc;
    logic                r_inflightLive;

    logic [GPR_SIZE-1:0] w_reqAddr;
    logic [GPR_SIZE-1:0] w_branchTarget;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W:0]      w_occupancy;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pushHlt;
    logic                w_pushBranch;
    logic                w_squashYounger;
    fetch_entry_t        w_head;
    fetch_entry_t        w_pushEntry;

    assign w_reqAddr   = {r_pc[GPR_SIZE-1:2], 2'b00};
    assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflightLive};
    assign w_push      = in_imem_valid && r_inflightLive && !in_rob_is_mispred;
    assign w_pushHlt   = w_push && (in_imem_insnbits == HLT_INSNBITS);
    assign w_pushEntry = '{insnbits: in_imem_insnbits, pc: r_inflightPc};

`ifdef FETCH_STATIC_BRANCH_EN
    assign w_pushBranch   = w_push && (in_imem_insnbits[31:26] == OP_B);
    assign w_branchTarget = branchTarget(r_inflightPc, in_imem_insnbits);
`else
    assign w_pushBranch   = 1'b0;
    assign w_branchTarget = '0;
`endif

    // A request issued while HLT or a taken B is being enqueued is on the wrong path.
    assign w_squashYounger = w_pushHlt || w_pushBranch;

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .i_clk      (in_clk),
        .i_rstN     (in_rst),
        .i_push     (w_push),
        .i_pushEntry(w_pushEntry),
        .i_pop      (out_d_done),
        .i_flush    (in_rob_is_mispred),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    assign out_imem_addr  = out_imem_req ? w_reqAddr : '0;
    assign out_d_insnbits = w_head.insnbits;
    assign out_d_pc       = w_head.pc;

    // State register.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) r_state <= FETCH;
        else         r_state <= w_nextState;
    end

    // Next state: a redirect always resumes fetching; enqueuing HLT stops it.
    always_comb begin
        w_nextState = r_state;
        if (in_rob_is_mispred)                  w_nextState = FETCH;
        else if (r_state == FETCH && w_pushHlt) w_nextState = HALTED;
    end

    // Outputs: request only with room for the reply, deliver only when dispatch can take it.
    always_comb begin
        out_imem_req = in_rst && (r_state == FETCH) && !in_rob_is_mispred &&
                       !w_full && (w_occupancy < DEPTH_L);
        out_d_done   = !w_empty && !in_d_stall && !in_rob_is_mispred;
        out_halted   = (r_state == HALTED);
    end

    // PC and the single in-flight slot; a redirect overrides every other update.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_pc           <= RESET_PC;
            r_inflightPc   <= '0;
            r_inflightLive <= 1'b0;
        end else if (in_rob_is_mispred) begin
            r_pc           <= in_rob_redirect_pc;
            r_inflightLive <= 1'b0;
        end else begin
            r_inflightLive <= out_imem_req && !w_squashYounger;
            if (out_imem_req) r_inflightPc <= w_reqAddr;
            if (w_pushBranch)      r_pc <= w_branchTarget;
            else if (out_imem_req) r_pc <= r_pc + GPR_SIZE'(4);
        end
    end

endmodule

// File: tb/tb_fetch_module.sv
// Directed bench for fetch_module. A behavioural memory answers every request
// one cycle later with word 0x1000 + addr/4, except for optional HLT and B
// locations. Expected deliveries are queued as each scenario is set up and
// popped whenever the DUT asserts out_d_done.
// Build option: FETCH_STATIC_BRANCH_EN changes the expected branch stream.
module tb_fetch_module;
    import fetch_module_pkg::*;

    logic                in_clk = 1'b0;
    logic                in_rst;
    logic                out_imem_req;
    logic [GPR_SIZE-1:0] out_imem_addr;
    logic                in_imem_valid;
    logic [31:0]         in_imem_insnbits;
    logic                out_d_done;
    logic [31:0]         out_d_insnbits;
    logic [GPR_SIZE-1:0] out_d_pc;
    logic                in_d_stall;
    logic                in_rob_is_mispred;
    logic [GPR_SIZE-1:0] in_rob_redirect_pc;
    logic                out_halted;

    fetch_module #(
        .QUEUE_DEPTH(4),
        .RESET_PC   (64'h0)
    ) dut (
        .in_clk            (in_clk),
        .in_rst            (in_rst),
        .out_imem_req      (out_imem_req),
        .out_imem_addr     (out_imem_addr),
        .in_imem_valid     (in_imem_valid),
        .in_imem_insnbits  (in_imem_insnbits),
        .out_d_done        (out_d_done),
        .out_d_insnbits    (out_d_insnbits),
        .out_d_pc          (out_d_pc),
        .in_d_stall        (in_d_stall),
        .in_rob_is_mispred (in_rob_is_mispred),
        .in_rob_redirect_pc(in_rob_redirect_pc),
        .out_halted        (out_halted)
    );

    always #5 in_clk = ~in_clk;

    int          nAsserts  = 0;
    int          nFailures = 0;
    int          cycle;
    int          reqCount;
    int          nDone;
    int          firstDone;
    int          lastDone;
    int          expectedDeliveries;
    logic        memReq;
    logic [63:0] memAddr;
    logic [63:0] hltAddr;
    logic [63:0] brAddr;
    logic [63:0] expPc[$];

    logic        sReq;
    logic [63:0] sAddr;
    logic        sDone;
    logic [63:0] sPc;
    logic [31:0] sInsn;
    logic        sHalted;

    // Program image: sequential filler words plus optional HLT and B #+0x20.
    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == hltAddr)     return HLT_INSNBITS;
        else if (a == brAddr) return 32'h1400_0008;
        else                  return 32'h0000_1000 + a[33:2];
    endfunction

    // One comparison: counts it, and counts and reports it when it fails.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFailures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: apply inputs, sample mid-cycle, score deliveries, answer memory after the edge.
    task automatic applyStimulus(input logic stall, input logic mispred, input logic [63:0] rpc);
        logic [63:0] e;
        in_d_stall         = stall;
        in_rob_is_mispred  = mispred;
        in_rob_redirect_pc = rpc;
        @(negedge in_clk);
        sReq    = out_imem_req;
        sAddr   = out_imem_addr;
        sDone   = out_d_done;
        sPc     = out_d_pc;
        sInsn   = out_d_insnbits;
        sHalted = out_halted;
        if (sReq) reqCount++;
        memReq  = sReq;
        memAddr = sAddr;
        if (sDone) begin
            nDone++;
            if (firstDone < 0) firstDone = cycle;
            lastDone = cycle;
            checkOutput("sbHasEntry", 64'(expPc.size() != 0), 64'd1);
            if (expPc.size() != 0) begin
                e = expPc.pop_front();
                checkOutput("deliveredPc", sPc, e);
                checkOutput("deliveredInsn", 64'(sInsn), 64'(memWord(e)));
            end
        end
        @(posedge in_clk);
        #1;
        in_imem_valid    = memReq;
        in_imem_insnbits = memReq ? memWord(memAddr) : 32'h0;
        cycle++;
    endtask

    task automatic releaseReset();
        in_rst    = 1'b1;
        cycle     = 0;
        reqCount  = 0;
        nDone     = 0;
        firstDone = -1;
        lastDone  = -1;
    endtask

    // Reset for one edge, then release so the next cycle is cycle 0.
    task automatic startScenario();
        in_rst             = 1'b0;
        in_d_stall         = 1'b0;
        in_rob_is_mispred  = 1'b0;
        in_rob_redirect_pc = '0;
        in_imem_valid      = 1'b0;
        in_imem_insnbits   = '0;
        memReq             = 1'b0;
        @(posedge in_clk);
        #1;
        releaseReset();
    endtask

    task automatic endScenario();
        checkOutput("sbDrained", 64'(expPc.size()), 64'd0);
        expPc.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Req"},    64'(out_imem_req),   64'd0);
        checkOutput({tag, "Addr"},   out_imem_addr,       64'd0);
        checkOutput({tag, "Done"},   64'(out_d_done),     64'd0);
        checkOutput({tag, "Insn"},   64'(out_d_insnbits), 64'd0);
        checkOutput({tag, "Pc"},     out_d_pc,            64'd0);
        checkOutput({tag, "Halted"}, 64'(out_halted),     64'd0);
    endtask

    initial begin
        hltAddr = '1;
        brAddr  = '1;
        expPc.delete();
        in_rst             = 1'b0;
        in_d_stall         = 1'b0;
        in_rob_is_mispred  = 1'b0;
        in_rob_redirect_pc = '0;
        in_imem_valid      = 1'b0;
        in_imem_insnbits   = '0;
        memReq             = 1'b0;
        memAddr            = '0;
        #2;
        checkAllZero("reset");
        @(posedge in_clk);
        #1;
        releaseReset();

        // Basic streaming from RESET_PC.
        expPc = '{64'h0, 64'h4, 64'h8, 64'hC};
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("cyc0Req",  64'(sReq), 64'd1);
        checkOutput("cyc0Addr", sAddr,     64'h0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("cyc1Addr", sAddr,      64'h4);
        checkOutput("cyc1Done", 64'(sDone), 64'd0);
        repeat (4) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("basicFirstDone", 64'(firstDone), 64'd2);
        checkOutput("basicLastDone",  64'(lastDone),  64'd5);
        checkOutput("basicCount",     64'(nDone),     64'd4);
        endScenario();

        // Dispatch stall fills the FIFO, then drains without gaps.
        startScenario();
        expPc = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
        repeat (2) applyStimulus(1'b0, 1'b0, '0);
        repeat (10) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("stallReqOff", 64'(sReq),  64'd0);
        checkOutput("stallHoldPc", sPc,        64'h0);
        checkOutput("stallHoldIn", 64'(sInsn), 64'h1000);
        checkOutput("stallReqs",   64'(reqCount), 64'd4);
        repeat (5) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("stallFirstDone", 64'(firstDone), 64'd12);
        checkOutput("stallLastDone",  64'(lastDone),  64'd16);
        checkOutput("stallCount",     64'(nDone),     64'd5);
        endScenario();

        // Redirect while three entries are buffered.
        startScenario();
        repeat (2) applyStimulus(1'b0, 1'b0, '0);
        repeat (2) applyStimulus(1'b1, 1'b0, '0);
        expPc = '{64'h200, 64'h204, 64'h208};
        applyStimulus(1'b0, 1'b1, 64'h200);
        checkOutput("mispDone", 64'(sDone), 64'd0);
        checkOutput("mispReq",  64'(sReq),  64'd0);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("redirReq",  64'(sReq), 64'd1);
        checkOutput("redirAddr", sAddr,     64'h200);
        repeat (4) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("redirFirstDone", 64'(firstDone), 64'd7);
        checkOutput("redirCount",     64'(nDone),     64'd3);
        endScenario();

        // HLT at 0x8 stops fetch; a redirect to 0x40 resumes it.
        startScenario();
        hltAddr = 64'h8;
        expPc = '{64'h0, 64'h4, 64'h8};
        repeat (8) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("hltHalted", 64'(sHalted),  64'd1);
        checkOutput("hltReqOff", 64'(sReq),     64'd0);
        checkOutput("hltReqs",   64'(reqCount), 64'd4);
        checkOutput("hltCount",  64'(nDone),    64'd3);
        checkOutput("hltLast",   64'(lastDone), 64'd4);
        expPc.push_back(64'h40);
        expPc.push_back(64'h44);
        applyStimulus(1'b0, 1'b1, 64'h40);
        checkOutput("hltRedirHalted", 64'(sHalted), 64'd1);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("resumeHalted", 64'(sHalted), 64'd0);
        checkOutput("resumeAddr",   sAddr,        64'h40);
        repeat (3) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("resumeLast",  64'(lastDone), 64'd12);
        checkOutput("resumeCount", 64'(nDone),    64'd5);
        endScenario();
        hltAddr = '1;

        // Unconditional B #+0x20 at 0x10.
        startScenario();
        brAddr = 64'h10;
`ifdef FETCH_STATIC_BRANCH_EN
        expPc = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h30, 64'h34};
        expectedDeliveries = 7;
`else
        expPc = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h14, 64'h18, 64'h1C};
        expectedDeliveries = 8;
`endif
        repeat (10) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("branchCount", 64'(nDone),    64'(expectedDeliveries));
        checkOutput("branchLast",  64'(lastDone), 64'd9);
        endScenario();
        brAddr = '1;

        // Asynchronous reset with a response in flight; the stale reply is ignored.
        startScenario();
        expPc = '{64'h0, 64'h4};
        repeat (4) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("inflightBeforeReset", 64'(memReq), 64'd1);
        #1;
        in_rst = 1'b0;
        #1;
        checkAllZero("midReset");
        endScenario();
        @(posedge in_clk);
        #1;
        in_imem_valid    = 1'b1;
        in_imem_insnbits = 32'hDEAD_BEEF;
        memReq           = 1'b0;
        releaseReset();
        expPc = '{64'h0, 64'h4};
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("restartAddr", sAddr, 64'h0);
        repeat (3) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("restartFirstDone", 64'(firstDone), 64'd2);
        checkOutput("restartCount",     64'(nDone),     64'd2);
        endScenario();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFailures);
        $finish;
    end

endmodule
